// File: rtl/traffic_phase_sequencer_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic phase sequencer:
//   - phase_e      : phase_state encodings (GREEN / YELLOW / ALL_RED)
//   - MIN_DUR      : shortest duration a timed phase may run (seconds)
//   - lsb_index()  : lowest-set-bit priority encoder for emergency requests
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    localparam int MIN_DUR = 1;

    // Lowest-index set bit of an up-to-8-bit request vector; 0 when empty.
    // Scanning downward lets the lowest set bit overwrite any higher one.
    function automatic logic [2:0] lsb_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// traffic_phase_sequencer_if
// Bundles the configuration inputs, control inputs and the lamp / status
// outputs of the sequencer.
//   master : the sequencer (reads config/control, drives lamps/status)
//   slave  : the environment (drives config/control, reads lamps/status)
// Signals:
//   green_duration, yellow_duration, red_holding : phase lengths, seconds
//   mode_auto, manual_advance, emerg_req          : control
//   lamp_red/yellow/green                         : per-approach lamps
//   active_direction, countdown_sec, phase_state  : status for renderers
//   manual_yellow_transition, tick_1hz            : single-cycle pulses
// -----------------------------------------------------------------------------
interface traffic_phase_sequencer_if #(
    parameter int N_DIR = 4,
    parameter int DUR_W = 8
);
    localparam int DIR_W = $clog2(N_DIR);

    logic [DUR_W-1:0] green_duration;
    logic [DUR_W-1:0] yellow_duration;
    logic [DUR_W-1:0] red_holding;
    logic             mode_auto;
    logic             manual_advance;
    logic [N_DIR-1:0] emerg_req;

    logic [N_DIR-1:0] lamp_red;
    logic [N_DIR-1:0] lamp_yellow;
    logic [N_DIR-1:0] lamp_green;
    logic [DIR_W-1:0] active_direction;
    logic [DUR_W-1:0] countdown_sec;
    logic [1:0]       phase_state;
    logic             manual_yellow_transition;
    logic             tick_1hz;

    modport master (
        input  green_duration, yellow_duration, red_holding,
               mode_auto, manual_advance, emerg_req,
        output lamp_red, lamp_yellow, lamp_green, active_direction,
               countdown_sec, phase_state, manual_yellow_transition, tick_1hz
    );

    modport slave (
        output green_duration, yellow_duration, red_holding,
               mode_auto, manual_advance, emerg_req,
        input  lamp_red, lamp_yellow, lamp_green, active_direction,
               countdown_sec, phase_state, manual_yellow_transition, tick_1hz
    );

endinterface

// File: rtl/traffic_phase_sequencer_tick_prescaler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   clear : restart the count at 0 on the next edge (phase entry)
//   tick  : high while the count equals TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int             CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
// Round-robin GREEN -> YELLOW -> ALL_RED sequencer for N_DIR approaches with
// manual green hold and per-approach emergency pre-emption.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : traffic_phase_sequencer_if.master (config, control, lamps, status)
// -----------------------------------------------------------------------------
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int N_DIR    = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    traffic_phase_sequencer_if.master  bus
);
    localparam int DIR_W = $clog2(N_DIR);

    phase_e           state_q, state_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic [DIR_W-1:0] next_dir_q, next_dir_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             myt_q, myt_d;
    logic             presc_clear;
    logic             tick;

    logic             req_any;
    logic [2:0]       tgt_full;
    logic [DIR_W-1:0] tgt;
    logic [DIR_W-1:0] dir_inc;

    logic [N_DIR-1:0] red_v, yel_v, grn_v;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Timed phases never load zero; a zero setting runs for one second.
    function automatic logic [DUR_W-1:0] timed_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(MIN_DUR) : d;
    endfunction

    assign req_any  = |bus.emerg_req;
    assign tgt_full = lsb_index(8'(bus.emerg_req));
    assign tgt      = tgt_full[DIR_W-1:0];
    assign dir_inc  = (dir_q == DIR_W'(N_DIR - 1)) ? '0 : dir_q + DIR_W'(1);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        next_dir_d  = next_dir_q;
        cnt_d       = cnt_q;
        myt_d       = 1'b0;
        presc_clear = 1'b0;

        case (state_q)
            PH_GREEN: begin
                if (req_any && tgt != dir_q) begin
                    // Another approach needs the junction: end green now.
                    state_d     = PH_YELLOW;
                    cnt_d       = timed_dur(bus.yellow_duration);
                    presc_clear = 1'b1;
                end else if (req_any) begin
                    // Our own approach is the target: hold, countdown frozen.
                end else if (cnt_q == '0) begin
                    // A zero countdown in GREEN marks a manually held green.
                    if (bus.mode_auto) begin
                        cnt_d       = timed_dur(bus.green_duration);
                        presc_clear = 1'b1;
                    end else if (bus.manual_advance) begin
                        state_d     = PH_YELLOW;
                        cnt_d       = timed_dur(bus.yellow_duration);
                        myt_d       = 1'b1;
                        presc_clear = 1'b1;
                    end
                end else if (tick) begin
                    if (cnt_q <= DUR_W'(1)) begin
                        state_d     = PH_YELLOW;
                        cnt_d       = timed_dur(bus.yellow_duration);
                        presc_clear = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end

            PH_YELLOW: begin
                if (tick) begin
                    if (cnt_q <= DUR_W'(1)) begin
                        state_d     = PH_ALLRED;
                        cnt_d       = timed_dur(bus.red_holding);
                        next_dir_d  = req_any ? tgt : dir_inc;
                        presc_clear = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end

            default: begin  // PH_ALLRED
                if (tick) begin
                    if (cnt_q <= DUR_W'(1)) begin
                        // A request raised during clearance still steers.
                        state_d     = PH_GREEN;
                        dir_d       = req_any ? tgt : next_dir_q;
                        next_dir_d  = req_any ? tgt : next_dir_q;
                        cnt_d       = bus.mode_auto ? timed_dur(bus.green_duration) : '0;
                        presc_clear = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PH_ALLRED;
            dir_q      <= '0;
            next_dir_q <= '0;
            cnt_q      <= DUR_W'(1);
            myt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            next_dir_q <= next_dir_d;
            cnt_q      <= cnt_d;
            myt_q      <= myt_d;
        end
    end

    // Lamps decode straight from the registered phase so reset reaches them
    // without waiting for a clock edge.
    always_comb begin
        red_v = '1;
        yel_v = '0;
        grn_v = '0;
        if (state_q == PH_GREEN) begin
            grn_v[dir_q] = 1'b1;
            red_v[dir_q] = 1'b0;
        end else if (state_q == PH_YELLOW) begin
            yel_v[dir_q] = 1'b1;
            red_v[dir_q] = 1'b0;
        end
    end

    assign bus.lamp_red                 = red_v;
    assign bus.lamp_yellow              = yel_v;
    assign bus.lamp_green               = grn_v;
    assign bus.active_direction         = dir_q;
    assign bus.countdown_sec            = cnt_q;
    assign bus.phase_state              = state_q;
    assign bus.manual_yellow_transition = myt_q;
    assign bus.tick_1hz                 = tick;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_traffic_phase_sequencer
// Bench for traffic_phase_sequencer: a 4-approach instance (TICK_DIV=4) run
// through table-driven vectors, hand-written corner sequences and randomized
// stimulus against a behavioural model, plus a 3-approach instance checked for
// round-robin order.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sequencer;

    localparam int TDIV = 4;
    localparam int PG = 0, PY = 1, PR = 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst3_n = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_sequencer_if #(.N_DIR(4), .DUR_W(8)) bus ();
    traffic_phase_sequencer #(.N_DIR(4), .DUR_W(8), .TICK_DIV(TDIV)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    traffic_phase_sequencer_if #(.N_DIR(3), .DUR_W(8)) bus3 ();
    traffic_phase_sequencer #(.N_DIR(3), .DUR_W(8), .TICK_DIV(2)) dut3 (
        .clk   (clk),
        .reset (rst3_n),
        .bus   (bus3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (4 approaches) ----------------
    int m_ph, m_dir, m_next, m_cnt, m_pre, m_myt;

    function automatic int tgt_of(input logic [3:0] r);
        for (int k = 0; k < 4; k++) if (r[k]) return k;
        return -1;
    endfunction

    function automatic int fixdur(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic [11:0] lamps_of(input int ph, input int d);
        logic [3:0] r, y, g;
        r = 4'hF; y = 4'h0; g = 4'h0;
        if (ph == PG)      begin g[d] = 1'b1; r[d] = 1'b0; end
        else if (ph == PY) begin y[d] = 1'b1; r[d] = 1'b0; end
        return {r, y, g};
    endfunction

    task automatic model_reset();
        m_ph = PR; m_dir = 0; m_next = 0; m_cnt = 1; m_pre = 0; m_myt = 0;
    endtask

    // One clock edge of the junction, expressed as the phase rules.
    task automatic model_edge();
        bit tk, enter;
        int t;
        tk = (m_pre == TDIV - 1);
        enter = 0;
        m_myt = 0;
        t = tgt_of(bus.emerg_req);
        if (m_ph == PG) begin
            if (t >= 0 && t != m_dir) begin
                m_ph = PY; m_cnt = fixdur(int'(bus.yellow_duration)); enter = 1;
            end else if (t >= 0) begin
                // frozen
            end else if (m_cnt == 0) begin
                if (bus.mode_auto) begin
                    m_cnt = fixdur(int'(bus.green_duration)); enter = 1;
                end else if (bus.manual_advance) begin
                    m_ph = PY; m_cnt = fixdur(int'(bus.yellow_duration)); m_myt = 1; enter = 1;
                end
            end else if (tk) begin
                if (m_cnt == 1) begin
                    m_ph = PY; m_cnt = fixdur(int'(bus.yellow_duration)); enter = 1;
                end else m_cnt--;
            end
        end else if (tk) begin
            if (m_cnt > 1) m_cnt--;
            else if (m_ph == PY) begin
                m_ph = PR; m_cnt = fixdur(int'(bus.red_holding));
                m_next = (t >= 0) ? t : (m_dir + 1) % 4; enter = 1;
            end else begin
                m_dir = (t >= 0) ? t : m_next; m_next = m_dir; m_ph = PG;
                m_cnt = bus.mode_auto ? fixdur(int'(bus.green_duration)) : 0; enter = 1;
            end
        end
        m_pre = (enter || tk) ? 0 : m_pre + 1;
    endtask

    function automatic logic [31:0] model_pack();
        return {6'd0, 2'(m_ph), 2'(m_dir), 8'(m_cnt), lamps_of(m_ph, m_dir),
                1'(m_myt), 1'(m_pre == TDIV - 1)};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {6'd0, bus.phase_state, bus.active_direction, bus.countdown_sec,
                bus.lamp_red, bus.lamp_yellow, bus.lamp_green,
                bus.manual_yellow_transition, bus.tick_1hz};
    endfunction

    task automatic step();
        if (!rst_n) model_reset();
        else        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string n, input int ph, input int d, input int cnt);
        chk({n, "_phase"}, 32'(bus.phase_state), 32'(ph));
        chk({n, "_dir"},   32'(bus.active_direction), 32'(d));
        chk({n, "_cnt"},   32'(bus.countdown_sec), 32'(cnt));
        chk({n, "_lamps"}, 32'({bus.lamp_red, bus.lamp_yellow, bus.lamp_green}),
            32'(lamps_of(ph, d)));
    endtask

    task automatic check_reset(input string n);
        check_state(n, PR, 0, 1);
        chk({n, "_myt"},  32'(bus.manual_yellow_transition), 32'd0);
        chk({n, "_tick"}, 32'(bus.tick_1hz), 32'd0);
    endtask

    function automatic bit at_phase(input int ph, input int d);
        return (int'(bus.phase_state) == ph) && (d < 0 || int'(bus.active_direction) == d);
    endfunction

    task automatic wait_for(input string n, input int ph, input int d, input int budget);
        int cyc = 0;
        while (!at_phase(ph, d) && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        if (!at_phase(ph, d)) begin
            errors++;
            $display("FAIL %s: timeout, phase %0d dir %0d, wanted phase %0d dir %0d",
                     n, bus.phase_state, bus.active_direction, ph, d);
        end
    endtask

    typedef struct {
        logic [3:0] emerg;
        logic       auto_m;
        int         cycles;
        int         ph;
        int         dir;
        int         cnt;
        logic       tick;
    } vec_t;

    vec_t vt[10];
    int   g_entries[$];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bus.green_duration = 8'd3; bus.yellow_duration = 8'd2; bus.red_holding = 8'd1;
        bus.mode_auto = 1'b1; bus.manual_advance = 1'b0; bus.emerg_req = 4'b0000;
        bus3.green_duration = 8'd1; bus3.yellow_duration = 8'd1; bus3.red_holding = 8'd1;
        bus3.mode_auto = 1'b1; bus3.manual_advance = 1'b0; bus3.emerg_req = 3'b000;

        vt[0] = '{4'b0, 1'b1,  4, PG, 0, 3, 1'b0};
        vt[1] = '{4'b0, 1'b1,  3, PG, 0, 3, 1'b1};
        vt[2] = '{4'b0, 1'b1,  1, PG, 0, 2, 1'b0};
        vt[3] = '{4'b0, 1'b1,  4, PG, 0, 1, 1'b0};
        vt[4] = '{4'b0, 1'b1,  4, PY, 0, 2, 1'b0};
        vt[5] = '{4'b0, 1'b1,  4, PY, 0, 1, 1'b0};
        vt[6] = '{4'b0, 1'b1,  4, PR, 0, 1, 1'b0};
        vt[7] = '{4'b0, 1'b1,  4, PG, 1, 3, 1'b0};
        vt[8] = '{4'b0, 1'b1, 72, PG, 0, 3, 1'b0};
        vt[9] = '{4'b0, 1'b1,  1, PG, 0, 3, 1'b0};

        repeat (3) step();
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bus.emerg_req = vt[i].emerg;
            bus.mode_auto = vt[i].auto_m;
            for (int c = 0; c < vt[i].cycles; c++) step();
            check_state($sformatf("vec%0d", i), vt[i].ph, vt[i].dir, vt[i].cnt);
            chk($sformatf("vec%0d_tick", i), 32'(bus.tick_1hz), 32'(vt[i].tick));
        end

        // Emergency for approaches 1 and 3 during GREEN(0).
        bus.emerg_req = 4'b1010;
        step();
        check_state("preempt_yellow", PY, 0, 2);
        wait_for("preempt_allred", PR, 0, 20);
        wait_for("preempt_green1", PG, 1, 20);
        chk("preempt_green1_cnt", 32'(bus.countdown_sec), 32'd3);
        repeat (20) step();
        check_state("preempt_hold", PG, 1, 3);

        // Drop the request; switching to manual only affects the next green.
        bus.emerg_req = 4'b0000;
        bus.mode_auto = 1'b0;
        wait_for("timed_green_continues", PY, 1, 40);
        wait_for("manual_green2", PG, 2, 60);
        chk("manual_cnt0", 32'(bus.countdown_sec), 32'd0);
        repeat (40) step();
        check_state("manual_hold", PG, 2, 0);
        bus.manual_advance = 1'b1;
        step();
        bus.manual_advance = 1'b0;
        check_state("manual_yellow", PY, 2, 2);
        chk("manual_myt_pulse", 32'(bus.manual_yellow_transition), 32'd1);
        step();
        chk("manual_myt_clear", 32'(bus.manual_yellow_transition), 32'd0);

        // Zero green lasts one tick; a mid-phase change waits for the next green.
        bus.mode_auto = 1'b1;
        bus.green_duration = 8'd0;
        wait_for("zero_green3", PG, 3, 60);
        chk("zero_green_cnt", 32'(bus.countdown_sec), 32'd1);
        bus.green_duration = 8'd5;
        repeat (3) step();
        chk("zero_green_held", 32'(bus.phase_state), 32'(PG));
        step();
        check_state("zero_green_end", PY, 3, 2);
        wait_for("new_green0", PG, 0, 60);
        chk("new_green_cnt", 32'(bus.countdown_sec), 32'd5);
        bus.green_duration = 8'd3;

        // Asynchronous reset in the middle of a yellow.
        wait_for("reach_yellow", PY, -1, 100);
        #3 rst_n = 1'b0;
        #1 check_reset("async_reset");
        step();
        step();
        rst_n = 1'b1;

        // Randomized stimulus against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0)
                bus.emerg_req = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            if ($urandom_range(0, 99) == 0) bus.mode_auto = ~bus.mode_auto;
            bus.manual_advance = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.green_duration  = 8'($urandom_range(0, 3));
                bus.yellow_duration = 8'($urandom_range(0, 3));
                bus.red_holding     = 8'($urandom_range(0, 3));
            end
            step();
            chk($sformatf("random%0d", i), dut_pack(), model_pack());
        end

        // Three-approach instance: round-robin order and index range.
        rst3_n = 1'b1;
        begin
            logic [1:0] prev_ph;
            prev_ph = bus3.phase_state;
            for (int c = 0; c < 60; c++) begin
                step();
                chk("n3_dir_range", 32'(bus3.active_direction < 2'd3), 32'd1);
                if (bus3.phase_state == 2'd0 && prev_ph != 2'd0)
                    g_entries.push_back(int'(bus3.active_direction));
                prev_ph = bus3.phase_state;
            end
        end
        chk("n3_entries", 32'(g_entries.size() >= 4), 32'd1);
        if (g_entries.size() >= 4) begin
            chk("n3_seq0", 32'(g_entries[0]), 32'd0);
            chk("n3_seq1", 32'(g_entries[1]), 32'd1);
            chk("n3_seq2", 32'(g_entries[2]), 32'd2);
            chk("n3_seq3", 32'(g_entries[3]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Parametrised successor of the fixed 4-way light controller feeding the display top. Sequences N_DIR approaches through GREEN -> YELLOW -> ALL_RED clearance, round-robin. Adds a per-approach emergency pre-emption mode and a configurable prescaler. Drives per-approach lamp vectors plus the countdown and active direction consumed by the text renderer and shape renderer.

Parameters:
N_DIR, 4, number of approaches (2..8)
DUR_W, 8, width of duration and countdown fields (seconds)
TICK_DIV, 100_000_000, clk cycles per 1 s tick (set small in simulation)
DIR_W, $clog2(N_DIR), width of direction index (derived, not overridable)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
green_duration  in  DUR_W  green time, seconds
yellow_duration  in  DUR_W  yellow time, seconds
red_holding  in  DUR_W  all-red clearance time, seconds
mode_auto  in  1  1 = timed green; 0 = green held until manual_advance
manual_advance  in  1  single-cycle pulse from button_controller; ends a manual green
emerg_req  in  N_DIR  level request per approach, bit k = approach k
lamp_red  out  N_DIR  red lamp per approach
lamp_yellow  out  N_DIR  yellow lamp per approach
lamp_green  out  N_DIR  green lamp per approach
active_direction  out  DIR_W  approach owning current/last green
countdown_sec  out  DUR_W  seconds remaining in the current phase
phase_state  out  2  0 GREEN, 1 YELLOW, 2 ALL_RED, 3 unused
manual_yellow_transition  out  1  1-cycle pulse when manual_advance starts a YELLOW
tick_1hz  out  1  1-cycle prescaler pulse

Behaviour:
- Reset (async assert, sync release): state ALL_RED, active_direction 0, next_dir 0, countdown_sec 1, lamp_red all 1s, lamp_yellow/lamp_green 0, manual_yellow_transition 0, prescaler 0, tick_1hz 0.
- Prescaler counts 0..TICK_DIV-1; tick_1hz = 1 on the cycle the count equals TICK_DIV-1. Cleared to 0 on every phase entry so each phase starts with a full second.
- On tick with countdown_sec > 1: decrement. On tick with countdown_sec == 1: take the transition. Exception: GREEN with mode_auto = 0 holds at countdown 0 and never times out.
- Transitions are registered: new state, lamps, and reloaded countdown are visible the cycle after the tick.
- GREEN(d) -> YELLOW(d), loads yellow_duration.
- YELLOW(d) -> ALL_RED, loads red_holding. next_dir = pre-emption target if any, else (d+1) mod N_DIR.
- ALL_RED -> GREEN(next_dir), loads green_duration (or 0 in manual mode). active_direction <= next_dir.
- Durations are sampled only at phase entry. Later input changes do not affect the running phase.
- A loaded duration of 0 is treated as 1 in timed phases.
- Manual mode: manual_advance in GREEN -> YELLOW on the next edge, pulses manual_yellow_transition, and clears the prescaler. manual_advance outside GREEN is ignored. manual_advance is ignored when mode_auto = 1.
- mode_auto changes take effect at the next GREEN entry. Exception: switching 0->1 during a held GREEN loads green_duration immediately.
- Pre-emption target = lowest-index set bit of emerg_req.
  - In GREEN(d) with any request for an approach other than d: YELLOW on the next edge, no tick needed.
  - In GREEN(d) with request for d only: hold green, countdown frozen, until the request drops. Then resume normal timing from the frozen value.
  - In YELLOW and ALL_RED, requests only steer next_dir.
- Lamp encoding per approach k: GREEN(d) gives green[d] = 1, all others red. YELLOW(d) gives yellow[d] = 1, all others red. ALL_RED gives all red. Exactly one lamp per approach is lit, always.
- active_direction never exceeds N_DIR-1; round-robin wraps N_DIR-1 -> 0.

Decomposition:
- Shared package traffic_pkg: phase_state encodings (PH_GREEN, PH_YELLOW, PH_ALLRED), minimum-duration constant 1, lowest-set-bit priority function.
- Sub-module tick_prescaler: parameter TICK_DIV; ports clk, reset, clear, tick.
- FSM, countdown and lamp decode stay in the top of this block.

Test Plan:
- TICK_DIV=4, N_DIR=4, durations 3/2/1, auto. Release reset -> after 1 tick GREEN(0) with countdown 3, then YELLOW(0) 2, ALL_RED 1, GREEN(1). Full cycle returns to GREEN(0) after 4*(3+2+1) ticks.
- Manual mode, GREEN(2). Hold 10 ticks -> still green, countdown 0. manual_advance pulse -> next cycle YELLOW(2), manual_yellow_transition = 1 for one cycle.
- GREEN(0), countdown 3, emerg_req = 4'b1010 -> YELLOW(0) next edge, ALL_RED, then GREEN(1) (lowest set bit). Hold the request -> green[1] stays lit and the countdown stays frozen.
- green_duration = 0 -> GREEN lasts exactly 1 tick. Change green_duration mid-GREEN -> current phase unaffected, next GREEN uses the new value.
- N_DIR=3 override -> sequence 0, 1, 2, 0, and active_direction never reaches 3.
- Drive reset low mid-YELLOW -> all outputs take reset values immediately (asynchronously), before the next clk edge.
